// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchy scan node.
// Optional feature macro used by this block: HIER_NODE_PARITY_EN.
package hier_node_pkg;

  // Report scan FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2
  } scan_state_e;

  // Widest supported leaf counter; snapshot records are packed at this width
  localparam int SNAP_CNT_MAX_W = 32;

  // Packed snapshot record: {sat, count zero-extended to SNAP_CNT_MAX_W}
  typedef logic [SNAP_CNT_MAX_W:0] snap_rec_t;

  // $clog2 that never returns less than 1 (keeps a 1-bit id for one child)
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic snap_rec_t snap_pack(input logic [SNAP_CNT_MAX_W-1:0] count,
                                          input logic sat);
    return {sat, count};
  endfunction

  function automatic logic [SNAP_CNT_MAX_W-1:0] rec_count(input snap_rec_t rec);
    return rec[SNAP_CNT_MAX_W-1:0];
  endfunction

  function automatic logic rec_sat(input snap_rec_t rec);
    return rec[SNAP_CNT_MAX_W];
  endfunction

endpackage

// File: rtl/hier_node_scan_leaf.sv
// Leaf event counter with a saturating live count, sticky saturation flag
// and a snapshot register pair. The snapshot outputs bypass to the live
// values during the snapshot cycle so the parent can register the first
// record in the same edge that takes the snapshot.
module hier_leaf_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             evt_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] snap_count_o,
  output logic             snap_sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic             sat_q;
  logic [CNT_W-1:0] snap_count_q;
  logic             snap_sat_q;

  // Live counting and snapshot capture; an event in the snapshot cycle
  // belongs to the new interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      sat_q        <= 1'b0;
      snap_count_q <= '0;
      snap_sat_q   <= 1'b0;
    end else if (snap_i) begin
      snap_count_q <= count_q;
      snap_sat_q   <= sat_q;
      count_q      <= {{(CNT_W-1){1'b0}}, evt_i};
      sat_q        <= 1'b0;
    end else if (evt_i) begin
      if (count_q == CNT_MAX) begin
        sat_q <= 1'b1;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign snap_count_o = snap_i ? count_q : snap_count_q;
  assign snap_sat_o   = snap_i ? sat_q   : snap_sat_q;

endmodule

// File: rtl/hier_node_scan.sv
// Hierarchy node: NUM_CHILD leaf counters snapshotted together on start_i,
// then reported one record per child in ascending index order.
// Optional feature macro: HIER_NODE_PARITY_EN (adds rpt_parity_o).
//
// Handshake: a record transfers on a cycle where rpt_valid_o && rpt_ready_i.
// While rpt_valid_o is high and rpt_ready_i is low, every rpt_* output holds
// its value, and rpt_valid_o never drops without a transfer.
module hier_node_scan
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILD = 5,
  parameter int CNT_W     = 8,
  localparam int ID_W     = clog2_min1(NUM_CHILD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [NUM_CHILD-1:0] evt_i,
  output logic                 busy_o,
  output logic                 rpt_valid_o,
  input  logic                 rpt_ready_i,
  output logic [ID_W-1:0]      rpt_id_o,
  output logic [CNT_W-1:0]     rpt_count_o,
  output logic                 rpt_sat_o,
  output logic                 rpt_last_o
`ifdef HIER_NODE_PARITY_EN
  ,
  output logic                 rpt_parity_o
`endif
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CHILD - 1);

  scan_state_e      state_q, state_d;
  scan_state_e      dbg_state;
  logic             snap;
  logic             load;
  logic [ID_W-1:0]  sel_idx;
  snap_rec_t        sel_rec;

  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             last_q, last_d;

  logic [CNT_W-1:0] snap_count [NUM_CHILD];
  logic             snap_sat   [NUM_CHILD];

  // One leaf per child; all share the same snapshot strobe
  for (genvar k = 0; k < NUM_CHILD; k++) begin : inst
    hier_leaf_counter #(
      .CNT_W(CNT_W)
    ) leaf (
      .clk          (clk),
      .rst_n        (rst_n),
      .evt_i        (evt_i[k]),
      .snap_i       (snap),
      .snap_count_o (snap_count[k]),
      .snap_sat_o   (snap_sat[k])
    );
  end

  // Child whose snapshot feeds the next registered record
  always_comb begin
    sel_idx = '0;
    if (state_q == SCAN && id_q != LAST_ID) begin
      sel_idx = id_q + 1'b1;
    end
    sel_rec = snap_pack(SNAP_CNT_MAX_W'(snap_count[sel_idx]), snap_sat[sel_idx]);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-record logic
  always_comb begin
    state_d = state_q;
    snap    = 1'b0;
    load    = 1'b0;
    valid_d = valid_q;
    busy_d  = busy_q;
    id_d    = id_q;
    count_d = count_q;
    sat_d   = sat_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          snap    = 1'b1;
          load    = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (valid_q && rpt_ready_i) begin
          if (id_q == LAST_ID) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            state_d = WAIT;
          end else begin
            load = 1'b1;
          end
        end
      end
      WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load) begin
      id_d    = sel_idx;
      count_d = CNT_W'(rec_count(sel_rec));
      sat_d   = rec_sat(sel_rec);
      last_d  = (sel_idx == LAST_ID);
    end
  end

  // Registered report outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      last_q  <= last_d;
    end
  end

`ifdef HIER_NODE_PARITY_EN
  logic parity_q;

  // Parity is captured with the record it covers, so it holds under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^{sat_d, id_d, count_d};
    end
  end

  assign rpt_parity_o = parity_q;
`endif

  assign dbg_state   = state_q;
  assign busy_o      = busy_q;
  assign rpt_valid_o = valid_q;
  assign rpt_id_o    = id_q;
  assign rpt_count_o = count_q;
  assign rpt_sat_o   = sat_q;
  assign rpt_last_o  = last_q;

endmodule

// File: tb/tb_hier_node_scan.sv
// Directed bench for hier_node_scan: a 5-child/8-bit node for scan order,
// backpressure, snapshot-edge events, ignored starts and mid-scan reset,
// plus a 1-child/4-bit node for saturation and the single-child case.
module tb_hier_node_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       start_i = 1'b0;
  logic [4:0] evt_i = '0;
  logic       rpt_ready_i = 1'b0;
  logic       busy_o;
  logic       rpt_valid_o;
  logic [2:0] rpt_id_o;
  logic [7:0] rpt_count_o;
  logic       rpt_sat_o;
  logic       rpt_last_o;
  logic       rpt_parity_o;

  logic       s_start = 1'b0;
  logic [0:0] s_evt = '0;
  logic       s_ready = 1'b0;
  logic       s_busy;
  logic       s_valid;
  logic [0:0] s_id;
  logic [3:0] s_count;
  logic       s_sat;
  logic       s_last;
  logic       s_parity;

  int         n_pass = 0;
  int         n_total = 0;
  int         busy_cnt;
  logic [7:0] exp_cnt [5];

  always #5 clk = ~clk;

  hier_node_scan #(.NUM_CHILD(5), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .evt_i        (evt_i),
    .busy_o       (busy_o),
    .rpt_valid_o  (rpt_valid_o),
    .rpt_ready_i  (rpt_ready_i),
    .rpt_id_o     (rpt_id_o),
    .rpt_count_o  (rpt_count_o),
    .rpt_sat_o    (rpt_sat_o),
    .rpt_last_o   (rpt_last_o)
`ifdef HIER_NODE_PARITY_EN
    ,
    .rpt_parity_o (rpt_parity_o)
`endif
  );

  hier_node_scan #(.NUM_CHILD(1), .CNT_W(4)) dut_one (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (s_start),
    .evt_i        (s_evt),
    .busy_o       (s_busy),
    .rpt_valid_o  (s_valid),
    .rpt_ready_i  (s_ready),
    .rpt_id_o     (s_id),
    .rpt_count_o  (s_count),
    .rpt_sat_o    (s_sat),
    .rpt_last_o   (s_last)
`ifdef HIER_NODE_PARITY_EN
    ,
    .rpt_parity_o (s_parity)
`endif
  );

`ifndef HIER_NODE_PARITY_EN
  assign rpt_parity_o = 1'b0;
  assign s_parity     = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Child k receives ck events on consecutive cycles starting now
  task automatic give_events(input int c0, input int c1, input int c2, input int c3, input int c4);
    for (int c = 0; c < 16; c++) begin
      evt_i = {c < c4, c < c3, c < c2, c < c1, c < c0};
      if (evt_i == 5'b0) break;
      tick();
    end
    evt_i = '0;
  endtask

  // Full scan of dut against exp_cnt; optional stall on one record, optional
  // start pulses (with a child-0 event) mid-scan and in WAIT.
  task automatic run_scan(input int stall_id, input int stall_len,
                          input logic [4:0] start_evt, input bit ign);
    evt_i       = start_evt;
    start_i     = 1'b1;
    rpt_ready_i = 1'b1;
    tick();
    start_i  = 1'b0;
    evt_i    = '0;
    busy_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      chk("rec_valid", 32'(rpt_valid_o), 32'd1);
      chk("rec_id",    32'(rpt_id_o),    32'(k));
      chk("rec_count", 32'(rpt_count_o), 32'(exp_cnt[k]));
      chk("rec_sat",   32'(rpt_sat_o),   32'd0);
      chk("rec_last",  32'(rpt_last_o),  32'(k == 4));
`ifdef HIER_NODE_PARITY_EN
      chk("rec_parity", 32'(rpt_parity_o), 32'(^{1'b0, 3'(k), exp_cnt[k]}));
`endif
      if (busy_o) busy_cnt++;
      if (k == stall_id) begin
        rpt_ready_i = 1'b0;
        repeat (stall_len) begin
          tick();
          chk("stall_valid", 32'(rpt_valid_o), 32'd1);
          chk("stall_id",    32'(rpt_id_o),    32'(k));
          chk("stall_count", 32'(rpt_count_o), 32'(exp_cnt[k]));
          chk("stall_last",  32'(rpt_last_o),  32'(k == 4));
        end
        rpt_ready_i = 1'b1;
      end
      if (ign && k == 1) begin
        start_i = 1'b1;
        evt_i   = 5'b00001;
      end
      tick();
      start_i = 1'b0;
      evt_i   = '0;
    end
    chk("wait_valid", 32'(rpt_valid_o), 32'd0);
    chk("wait_busy",  32'(busy_o),      32'd0);
    chk("wait_last",  32'(rpt_last_o),  32'd0);
    if (ign) begin
      start_i = 1'b1;
      evt_i   = 5'b00001;
    end
    tick();
    start_i = 1'b0;
    evt_i   = '0;
    chk("idle_valid",  32'(rpt_valid_o), 32'd0);
    chk("idle_busy",   32'(busy_o),      32'd0);
    chk("busy_cycles", 32'(busy_cnt),    32'd5);
  endtask

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_valid",  32'(rpt_valid_o),  32'd0);
    chk("rst_busy",   32'(busy_o),       32'd0);
    chk("rst_id",     32'(rpt_id_o),     32'd0);
    chk("rst_count",  32'(rpt_count_o),  32'd0);
    chk("rst_sat",    32'(rpt_sat_o),    32'd0);
    chk("rst_last",   32'(rpt_last_o),   32'd0);
    chk("rst_parity", 32'(rpt_parity_o), 32'd0);
    chk("rst1_valid", 32'(s_valid),      32'd0);
    chk("rst1_busy",  32'(s_busy),       32'd0);
    rst_n = 1'b1;
    tick();

    // Basic scan: counts 3,0,7,1,2
    give_events(3, 0, 7, 1, 2);
    exp_cnt = '{8'd3, 8'd0, 8'd7, 8'd1, 8'd2};
    run_scan(-1, 0, 5'b0, 1'b0);

    // Backpressure: 4-cycle stall on id2
    give_events(1, 2, 3, 4, 5);
    exp_cnt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    run_scan(2, 4, 5'b0, 1'b0);

    // Snapshot-edge event on child 1; ignored starts mid-scan and in WAIT
    give_events(0, 2, 0, 0, 0);
    exp_cnt = '{8'd0, 8'd2, 8'd0, 8'd0, 8'd0};
    run_scan(-1, 0, 5'b00010, 1'b1);

    // Next scan carries the start-cycle event and the two ignored-start events
    exp_cnt = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    run_scan(-1, 0, 5'b0, 1'b0);

    // Reset in the middle of a scan while id3 is presented
    give_events(1, 1, 1, 1, 1);
    start_i     = 1'b1;
    rpt_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    chk("pre_rst_id", 32'(rpt_id_o), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(rpt_valid_o),  32'd0);
    chk("mid_rst_busy",   32'(busy_o),       32'd0);
    chk("mid_rst_id",     32'(rpt_id_o),     32'd0);
    chk("mid_rst_count",  32'(rpt_count_o),  32'd0);
    chk("mid_rst_last",   32'(rpt_last_o),   32'd0);
    chk("mid_rst_parity", 32'(rpt_parity_o), 32'd0);
    tick();
    chk("mid_rst_hold_valid", 32'(rpt_valid_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Rerun after reset: earlier counts are gone
    give_events(0, 0, 0, 0, 3);
    exp_cnt = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd3};
    run_scan(-1, 0, 5'b0, 1'b0);

    // Single child, 4-bit counter: saturation then a clean interval
    s_evt = 1'b1;
    repeat (20) tick();
    s_evt   = 1'b0;
    s_ready = 1'b1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("one_valid",  32'(s_valid),  32'd1);
    chk("one_busy",   32'(s_busy),   32'd1);
    chk("one_id",     32'(s_id),     32'd0);
    chk("one_count",  32'(s_count),  32'd15);
    chk("one_sat",    32'(s_sat),    32'd1);
    chk("one_last",   32'(s_last),   32'd1);
`ifdef HIER_NODE_PARITY_EN
    chk("one_parity", 32'(s_parity), 32'd1);
`endif
    tick();
    chk("one_wait_valid", 32'(s_valid), 32'd0);
    chk("one_wait_last",  32'(s_last),  32'd0);
    tick();
    s_evt = 1'b1;
    repeat (2) tick();
    s_evt   = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("one2_valid", 32'(s_valid), 32'd1);
    chk("one2_count", 32'(s_count), 32'd2);
    chk("one2_sat",   32'(s_sat),   32'd0);
    chk("one2_last",  32'(s_last),  32'd1);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
